// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer: drain FSM encoding,
// default data width and the occupancy-counter width helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } tx_state_e;

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Circular byte store with write/read pointers and a registered occupancy
// count. Knows nothing about the transmitter; the caller decides when to pop.
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = UART_DATA_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;

    // A write into a full store is still taken when a pop frees a slot on the same edge.
    assign push    = wr_i && (!full_o || rd_i);
    assign drop_o  = wr_i && full_o && !rd_i;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array; contents after reset are don't-care so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at DEPTH-1; count tracks push/pop imbalance only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, rd_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART transmitter. Bytes are queued on
// wr_en and drained one at a time over the tx_req/tx_data/tx_busy handshake.
// Handshake: tx_req is a single-cycle pulse that the transmitter samples on
// the following edge, tx_data is held until the next pulse, and the
// transmitter acknowledges by raising tx_busy for the duration of the frame;
// a new request is only issued once tx_busy is low again.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = UART_DATA_W,
    parameter int BUSY_TMO = 3,
    localparam int CW      = cnt_width(DEPTH),
    localparam int TW      = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_err,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             lost,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_busy,
    output tx_state_e        dbg_state
);

    tx_state_e        state_q;
    logic [TW-1:0]    tmo_q;
    logic             tx_req_q;
    logic [WIDTH-1:0] tx_data_q;
    logic             overflow_q, overflow_d;
    logic             lost_q, lost_d;
    logic             pop;
    logic             drop;
    logic             lost_evt;
    logic [WIDTH-1:0] rdata;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (wr_en),
        .wdata_i (wr_data),
        .rd_i    (pop),
        .rdata_o (rdata),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty),
        .drop_o  (drop)
    );

    // The only pop point is leaving S_IDLE with a request.
    assign pop      = (state_q == S_IDLE) && !empty && !tx_busy && ena;
    assign lost_evt = (state_q == S_WAIT_BUSY) && !tx_busy && (tmo_q == TW'(BUSY_TMO - 1));

    // Drain FSM: request, then wait for busy to rise (bounded), then to fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tx_req_q  <= 1'b1;
                        tx_data_q <= rdata;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    tx_req_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (lost_evt) begin
                        // Byte is treated as consumed; no retry.
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sticky error flags: a new event in the same cycle beats clr_err.
    always_comb begin
        overflow_d = overflow_q;
        lost_d     = lost_q;
        if (clr_err) begin
            overflow_d = 1'b0;
            lost_d     = 1'b0;
        end
        if (drop)     overflow_d = 1'b1;
        if (lost_evt) lost_d     = 1'b1;
    end

    // Registered sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            lost_q     <= lost_d;
        end
    end

    assign overflow  = overflow_q;
    assign lost      = lost_q;
    assign tx_req    = tx_req_q;
    assign tx_data   = tx_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed stimulus, a transmitter model driving
// tx_busy, and a monitor that checks every emitted byte against exp_q.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          clr_err;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          lost;
  logic          tx_req;
  logic [W-1:0]  tx_data;
  logic          tx_busy;
  tx_state_e     dbg_state;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            tx_seen  = 0;
  int            mute_n   = 0;
  int            busy_len = 4;
  logic          mon_prev_req = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(W), .BUSY_TMO(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_err   (clr_err),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .lost      (lost),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; the write happens on the next rising edge.
  task automatic push_byte(input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && dbg_state == S_IDLE && !tx_busy && empty) && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  task automatic wait_state(input tx_state_e s, input int budget, input string name);
    int n = 0;
    while (dbg_state != s && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  // ---------------- transmitter model ----------------
  // Sees the request between edges, raises busy after the sampling edge.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_req) begin
        if (mute_n > 0) begin
          mute_n--;
        end else begin
          @(posedge clk);
          #1 tx_busy = 1'b1;
          repeat (busy_len) @(posedge clk);
          #1 tx_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev_req = 1'b0;
      end else begin
        if (mon_prev_req) check("tx_req_one_cycle", tx_req, 0);
        if (tx_req) begin
          tx_seen++;
          check("tx_expected_pending", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("tx_data_order", tx_data, exp_q.pop_front());
        end
        mon_prev_req = tx_req;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] wrap_v [20];
  int           base;
  int           n;

  initial begin
    wrap_v = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hA9,
               8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B};
    rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_data = '0; clr_err = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_lost", lost, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    tick();

    // Single byte: write at edge 0, request from edge 1 to edge 2
    push_byte(8'hA5);
    check("single_count_after_write", count, 1);
    check("single_no_req_yet", tx_req, 0);
    tick();
    check("single_req_high", tx_req, 1);
    check("single_tx_data", tx_data, 8'hA5);
    check("single_count_after_pop", count, 0);
    tick();
    check("single_req_low", tx_req, 0);
    wait_drained(100, "single_drain_timeout");
    check("single_empty_end", empty, 1);
    check("single_count_end", count, 0);

    // Fill with drain disabled, ninth write dropped
    ena  = 1'b0;
    base = tx_seen;
    for (int i = 0; i < 9; i++) begin
      wr_en   = 1'b1;
      wr_data = W'(i);
      if (i < DEPTH) exp_q.push_back(W'(i));
      tick();
    end
    wr_en = 1'b0;
    check("fill_full", full, 1);
    check("fill_count", count, 8);
    check("fill_overflow", overflow, 1);
    check("fill_no_req", tx_req, 0);

    // Overflow in the same cycle as clr_err: set wins
    wr_en = 1'b1; wr_data = 8'h99; clr_err = 1'b1;
    tick();
    wr_en = 1'b0; clr_err = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_count_unchanged", count, 8);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Push while full on the pop cycle is accepted
    ena = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    exp_q.push_back(8'h55);
    tick();
    wr_en = 1'b0;
    check("pushpop_count", count, 8);
    check("pushpop_full", full, 1);
    check("pushpop_overflow", overflow, 0);
    check("pushpop_req", tx_req, 1);
    wait_drained(400, "fill_drain_timeout");
    check("fill_emitted", tx_seen - base, 9);
    check("fill_overflow_end", overflow, 0);

    // Lost handshake: first request never acknowledged
    mute_n = 1;
    push_byte(8'h3C);
    push_byte(8'h3D);
    check("lost_req_3c", tx_req, 1);
    tick();
    check("lost_req_fell", tx_req, 0);
    check("lost_wait_busy", dbg_state, S_WAIT_BUSY);
    tick();
    check("lost_low_1", lost, 0);
    tick();
    check("lost_low_2", lost, 0);
    tick();
    check("lost_set", lost, 1);
    check("lost_back_idle", dbg_state, S_IDLE);
    tick();
    check("lost_next_req", tx_req, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("lost_cleared", lost, 0);
    wait_drained(100, "lost_drain_timeout");
    check("lost_stays_clear", lost, 0);

    // Wrap-around with random gaps
    busy_len = 2;
    base     = tx_seen;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      n = 0;
      while (full && n < 100) begin
        tick();
        n++;
      end
      check("wrap_full_wait", (n < 100), 1);
      push_byte(wrap_v[i]);
      check("wrap_count_le_depth", (count <= CW'(DEPTH)), 1);
    end
    wait_drained(600, "wrap_drain_timeout");
    check("wrap_emitted", tx_seen - base, 20);
    check("wrap_no_overflow", overflow, 0);

    // Reset in S_WAIT_DONE with three bytes left
    busy_len = 6;
    ena = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    ena = 1'b1;
    wait_state(S_WAIT_DONE, 50, "rst_mid_reach_done");
    check("rst_mid_count_before", count, 3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_count", count, 0);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_full", full, 0);
    check("rst_mid_tx_req", tx_req, 0);
    check("rst_mid_state", dbg_state, S_IDLE);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    base  = tx_seen;
    repeat (20) tick();
    check("rst_mid_no_req", tx_seen - base, 0);
    check("rst_mid_still_empty", count, 0);
    push_byte(8'h7E);
    wait_drained(100, "rst_mid_drain_timeout");
    check("rst_mid_new_byte", tx_seen - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer that sits directly upstream of the team's UART transmitter.
- Accepts bytes from the host/core side through a write strobe and stores them in a circular FIFO.
- Drains the FIFO into the transmitter one byte at a time through its tx_req/tx_data/tx_busy handshake.
- Decouples bursty producers from the serial bit rate and reports overflow and lost-handshake errors.

Parameters:
- DEPTH, 8, number of byte entries; power of two, minimum 2.
- WIDTH, 8, data width in bits; must match the transmitter data width.
- BUSY_TMO, 3, clocks to wait for tx_busy to rise after a request before declaring the handshake lost.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  drain enable; when 0, no new request is issued (writes are still accepted).
- wr_en  in  1  write strobe, one byte per cycle.
- wr_data  in  WIDTH  byte to enqueue.
- clr_err  in  1  synchronous clear for the sticky overflow and lost flags.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a write was dropped.
- lost  out  1  sticky; tx_busy did not rise within BUSY_TMO cycles after a request.
- tx_req  out  1  one-cycle request to the transmitter.
- tx_data  out  WIDTH  byte presented with tx_req; held stable until the next request.
- tx_busy  in  1  transmitter busy, returned from the transmitter.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, lost=0, tx_req=0, tx_data=0, FSM=S_IDLE, timeout counter=0. Memory contents are don't-care.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count is a registered value updated each edge: +1 on push only, -1 on pop only, unchanged on push and pop together. full and empty are derived from count.
- Push occurs when wr_en=1 and (full=0 or a pop occurs in the same cycle).
- wr_en=1 while full=1 with no pop in the same cycle: the data is dropped, overflow is set to 1, and the pointers and count are unchanged.
- Pop occurs only on the S_IDLE to S_REQ transition.
- FSM S_IDLE: if empty=0, tx_busy=0 and ena=1, then at the next edge: tx_req<=1, tx_data<=mem[rd_ptr], rd_ptr++, go to S_REQ. Otherwise stay in S_IDLE.
- FSM S_REQ: at the next edge, tx_req<=0, timeout counter<=0, go to S_WAIT_BUSY. tx_req is therefore high for exactly one cycle.
- FSM S_WAIT_BUSY: if tx_busy=1, go to S_WAIT_DONE. Else if the timeout counter equals BUSY_TMO-1, set lost<=1 and go to S_IDLE; the byte is considered consumed and is not retried. Else increment the timeout counter.
- FSM S_WAIT_DONE: when tx_busy=0, go to S_IDLE.
- Consequence: back-to-back bytes have at least one idle cycle between the fall of tx_busy and the next tx_req.
- Latency: a write into an empty FIFO at edge 0 (transmitter idle, ena=1) gives tx_req high from edge 1 to edge 2. The transmitter samples the request at edge 2 and tx_busy is high after edge 2.
- ena dropping to 0 mid-frame does not abort anything; it only blocks the next S_IDLE to S_REQ transition.
- clr_err=1 clears overflow and lost at the next edge. If an overflow or lost event occurs in the same cycle as clr_err, the set wins.
- Reset asserted mid-frame: the FIFO empties immediately and tx_req drops immediately. The transmitter is reset separately.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding typedef (S_IDLE, S_REQ, S_WAIT_BUSY, S_WAIT_DONE), 2 bits;
  - a UART_DATA_W=8 constant;
  - a function computing the count width from DEPTH.
- One natural sub-module, sync_fifo_mem: the dual-pointer register array with the push/pop/count logic and no handshake knowledge.
- uart_tx_fifo instantiates sync_fifo_mem and adds the drain FSM, the timeout counter and the sticky flags.

Test Plan:
- Single byte: after reset, write 0xA5 at edge 0 with tx_busy model idle -> tx_req pulses for one cycle at edge 1 with tx_data=0xA5. After tx_busy rises then falls, empty=1 and count=0.
- Fill and overflow (DEPTH=8, ena=0): write 0x00..0x08 -> full=1, count=8, overflow=1. Then ena=1 -> exactly 0x00..0x07 are emitted in order, one per tx_busy cycle.
- Simultaneous push and pop when full: write 0x55 on the same cycle as the S_IDLE to S_REQ pop -> write accepted, count stays 8, overflow stays 0.
- Lost handshake: tx_busy held at 0 after a request for 0x3C -> lost=1 three cycles after tx_req falls, FSM returns to S_IDLE and the next byte is requested. clr_err -> lost=0.
- Wrap-around: 20 write/drain cycles with a random interleave -> output sequence equals input sequence and count never exceeds 8.
- Reset mid-frame: assert rst_n=0 while in S_WAIT_DONE with count=3 -> immediately count=0, empty=1, tx_req=0. After release, no request is issued until a new write.
